// File: rtl/cpu_pkg.sv
// Shared constants, instruction-field positions and control types for the
// single-cycle 16-bit core.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int PC_W   = 8;
  localparam int NREG   = 8;
  localparam int NMEM   = 8;
  localparam int IDX_W  = 3;

  // Opcodes; 10..15 are NOPs and have no named constant.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SUBI = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_JMP  = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd9;

  // Instruction field bit positions.
  localparam int OPC_LSB    = 0;
  localparam int OPC_MSB    = 3;
  localparam int DST_LSB    = 4;
  localparam int DST_MSB    = 6;
  localparam int SRC1_LSB   = 7;
  localparam int SRC1_MSB   = 9;
  localparam int SRC2_LSB   = 10;
  localparam int SRC2_MSB   = 12;
  localparam int SHAMT_LSB  = 13;
  localparam int SHAMT_MSB  = 15;
  localparam int ICONST_LSB = 10;
  localparam int ICONST_MSB = 15;
  localparam int ICONST_W   = 6;
  localparam int SHAMT_W    = 3;
  // Jump target: the low PC_W bits of jconst (instr[12:4]); jconst[8] is dropped.
  localparam int JTGT_LSB   = 4;
  localparam int JTGT_MSB   = JTGT_LSB + PC_W - 1;

  // ALU operand-B select.
  typedef enum logic [1:0] {
    ALUSRC_REG   = 2'b00,
    ALUSRC_IMM   = 2'b01,
    ALUSRC_SHAMT = 2'b10
  } alusrc_e;

  // Decoded controls and fields consumed by the datapath.
  typedef struct packed {
    logic                reg_write;
    logic                mem_write;
    logic                mem_to_reg;
    alusrc_e             alu_src;
    logic [3:0]          alu_op;
    logic [IDX_W-1:0]    dst;
    logic [IDX_W-1:0]    src1;
    logic [IDX_W-1:0]    src2;
    logic [SHAMT_W-1:0]  shamt;
    logic [ICONST_W-1:0] iconst;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] zext_iconst(input logic [ICONST_W-1:0] v);
    return {{(DATA_W-ICONST_W){1'b0}}, v};
  endfunction

  function automatic logic [DATA_W-1:0] zext_shamt(input logic [SHAMT_W-1:0] v);
    return {{(DATA_W-SHAMT_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/cpu_core_if.sv
// Instruction-memory bus: the core presents pc, the memory returns instr
// combinationally.
interface cpu_core_if;
  import cpu_pkg::*;

  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] instr;

  modport master (output pc, input instr);
  modport slave  (input pc, output instr);
endinterface

// File: rtl/control_unit.sv
// Combinational instruction field split and control decode.
module control_unit
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] instr_i,
  output ctrl_t             ctrl_o,
  output logic              pc_src_o,
  output logic [PC_W-1:0]   jmp_tgt_o
);

  logic [3:0] opcode_s;

  assign opcode_s  = instr_i[OPC_MSB:OPC_LSB];
  assign jmp_tgt_o = instr_i[JTGT_MSB:JTGT_LSB];

  // Decode: NOP and JMP leave the ALU doing ADD on R[src1]+R[src2] but write nothing.
  always_comb begin
    ctrl_o.reg_write  = 1'b0;
    ctrl_o.mem_write  = 1'b0;
    ctrl_o.mem_to_reg = 1'b0;
    ctrl_o.alu_src    = ALUSRC_REG;
    ctrl_o.alu_op     = OP_ADD;
    ctrl_o.dst        = instr_i[DST_MSB:DST_LSB];
    ctrl_o.src1       = instr_i[SRC1_MSB:SRC1_LSB];
    ctrl_o.src2       = instr_i[SRC2_MSB:SRC2_LSB];
    ctrl_o.shamt      = instr_i[SHAMT_MSB:SHAMT_LSB];
    ctrl_o.iconst     = instr_i[ICONST_MSB:ICONST_LSB];
    pc_src_o          = 1'b0;
    case (opcode_s)
      OP_ADD: begin
        ctrl_o.reg_write = 1'b1;
      end
      OP_SLL: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = ALUSRC_SHAMT;
        ctrl_o.alu_op    = OP_SLL;
      end
      OP_SRL: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = ALUSRC_SHAMT;
        ctrl_o.alu_op    = OP_SRL;
      end
      OP_AND: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = OP_AND;
      end
      OP_OR: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = OP_OR;
      end
      OP_SUBI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = ALUSRC_IMM;
        ctrl_o.alu_op    = OP_SUBI;
      end
      OP_ADDI: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = ALUSRC_IMM;
      end
      OP_LW: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src    = ALUSRC_IMM;
      end
      OP_JMP: begin
        pc_src_o = 1'b1;
      end
      OP_SW: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = ALUSRC_IMM;
      end
      default: begin
        pc_src_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Register file, ALU operand mux, ALU, data memory and write-back mux.
module datapath
  import cpu_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  ctrl_t                         ctrl_i,
  output logic [NREG-1:0][DATA_W-1:0]   regs_o,
  output logic [NMEM-1:0][DATA_W-1:0]   mem_o,
  output logic [DATA_W-1:0]             alu_in1_o,
  output logic [DATA_W-1:0]             alu_in2_o,
  output logic [DATA_W-1:0]             alu_out_o,
  output logic [DATA_W-1:0]             reg_data_in_o
);

  logic [NREG-1:0][DATA_W-1:0] rf_q;
  logic [NREG-1:0][DATA_W-1:0] rf_d;
  logic [NMEM-1:0][DATA_W-1:0] mem_q;
  logic [NMEM-1:0][DATA_W-1:0] mem_d;
  logic [DATA_W-1:0]           op_a_s;
  logic [DATA_W-1:0]           op_b_s;
  logic [DATA_W-1:0]           alu_s;
  logic [IDX_W-1:0]            addr_s;
  logic [DATA_W-1:0]           wb_s;

  assign op_a_s = rf_q[ctrl_i.src1];

  // Operand B select: register, zero-extended iconst or zero-extended shamt.
  always_comb begin
    op_b_s = rf_q[ctrl_i.src2];
    case (ctrl_i.alu_src)
      ALUSRC_REG:   op_b_s = rf_q[ctrl_i.src2];
      ALUSRC_IMM:   op_b_s = zext_iconst(ctrl_i.iconst);
      ALUSRC_SHAMT: op_b_s = zext_shamt(ctrl_i.shamt);
      default:      op_b_s = rf_q[ctrl_i.src2];
    endcase
  end

  // ALU: modulo-2^16 arithmetic, logical shifts, no flags.
  always_comb begin
    alu_s = op_a_s + op_b_s;
    case (ctrl_i.alu_op)
      OP_SLL:  alu_s = op_a_s << op_b_s[3:0];
      OP_SRL:  alu_s = op_a_s >> op_b_s[3:0];
      OP_AND:  alu_s = op_a_s & op_b_s;
      OP_OR:   alu_s = op_a_s | op_b_s;
      OP_SUBI: alu_s = op_a_s - op_b_s;
      default: alu_s = op_a_s + op_b_s;
    endcase
  end

  // Memory address wraps: only the low three ALU bits select a word.
  assign addr_s = alu_s[IDX_W-1:0];

  // Write-back select: memory read data for loads, else the ALU result.
  always_comb begin
    wb_s = alu_s;
    if (ctrl_i.mem_to_reg) begin
      wb_s = mem_q[addr_s];
    end else begin
      wb_s = alu_s;
    end
  end

  // Register-file next state: one write port, reads see the old contents.
  always_comb begin
    rf_d = rf_q;
    if (ctrl_i.reg_write) begin
      rf_d[ctrl_i.dst] = wb_s;
    end else begin
      rf_d = rf_q;
    end
  end

  // Data-memory next state: store R[dst] at the wrapped ALU address.
  always_comb begin
    mem_d = mem_q;
    if (ctrl_i.mem_write) begin
      mem_d[addr_s] = rf_q[ctrl_i.dst];
    end else begin
      mem_d = mem_q;
    end
  end

  // Architectural state registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_q  <= '0;
      mem_q <= '0;
    end else begin
      rf_q  <= rf_d;
      mem_q <= mem_d;
    end
  end

  assign regs_o        = rf_q;
  assign mem_o         = mem_q;
  assign alu_in1_o     = op_a_s;
  assign alu_in2_o     = op_b_s;
  assign alu_out_o     = alu_s;
  assign reg_data_in_o = wb_s;

endmodule

// File: rtl/prgm_counter.sv
// Program counter: increments by one (wrapping) or loads the jump target.
module prgm_counter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_src_i,
  input  logic [PC_W-1:0] jmp_tgt_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Next-PC selection: jump target or sequential increment.
  always_comb begin
    pc_d = pc_q + 8'd1;
    if (pc_src_i) begin
      pc_d = jmp_tgt_i;
    end else begin
      pc_d = pc_q + 8'd1;
    end
  end

  // PC register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= 8'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 16-bit core: instances of PC, decoder and datapath plus wiring.
module cpu_core
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  cpu_core_if.master        imem,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic [DATA_W-1:0] dataMemValue0,
  output logic [DATA_W-1:0] dataMemValue1,
  output logic [DATA_W-1:0] dataMemValue2,
  output logic [DATA_W-1:0] dataMemValue3,
  output logic [DATA_W-1:0] dataMemValue4,
  output logic [DATA_W-1:0] dataMemValue5,
  output logic [DATA_W-1:0] dataMemValue6,
  output logic [DATA_W-1:0] dataMemValue7,
  output logic [DATA_W-1:0] ALUin1,
  output logic [DATA_W-1:0] ALUin2,
  output logic [DATA_W-1:0] ALUout,
  output logic [DATA_W-1:0] regDataIn
);

  ctrl_t                       ctrl_s;
  logic                        pc_src_s;
  logic [PC_W-1:0]             jmp_tgt_s;
  logic [PC_W-1:0]             pc_s;
  logic [NREG-1:0][DATA_W-1:0] regs_s;
  logic [NMEM-1:0][DATA_W-1:0] mem_s;

  prgm_counter u_pc (
    .clk       (clk),
    .reset     (reset),
    .pc_src_i  (pc_src_s),
    .jmp_tgt_i (jmp_tgt_s),
    .pc_o      (pc_s)
  );

  control_unit u_ctrl (
    .instr_i   (imem.instr),
    .ctrl_o    (ctrl_s),
    .pc_src_o  (pc_src_s),
    .jmp_tgt_o (jmp_tgt_s)
  );

  datapath u_dp (
    .clk           (clk),
    .reset         (reset),
    .ctrl_i        (ctrl_s),
    .regs_o        (regs_s),
    .mem_o         (mem_s),
    .alu_in1_o     (ALUin1),
    .alu_in2_o     (ALUin2),
    .alu_out_o     (ALUout),
    .reg_data_in_o (regDataIn)
  );

  assign imem.pc = pc_s;

  assign reg0 = regs_s[0];
  assign reg1 = regs_s[1];
  assign reg2 = regs_s[2];
  assign reg3 = regs_s[3];
  assign reg4 = regs_s[4];
  assign reg5 = regs_s[5];
  assign reg6 = regs_s[6];
  assign reg7 = regs_s[7];

  assign dataMemValue0 = mem_s[0];
  assign dataMemValue1 = mem_s[1];
  assign dataMemValue2 = mem_s[2];
  assign dataMemValue3 = mem_s[3];
  assign dataMemValue4 = mem_s[4];
  assign dataMemValue5 = mem_s[5];
  assign dataMemValue6 = mem_s[6];
  assign dataMemValue7 = mem_s[7];

endmodule

// File: tb/tb_cpu_core.sv
// Scoreboard bench for cpu_core: a driver feeds instructions and pushes the
// expected outcome from an instruction-level model; a monitor pops and compares.
module tb_cpu_core;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_core_if imem ();

  logic [15:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [15:0] dm0, dm1, dm2, dm3, dm4, dm5, dm6, dm7;
  logic [15:0] alu_in1, alu_in2, alu_out, reg_data_in;

  cpu_core dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (imem),
    .reg0          (reg0),
    .reg1          (reg1),
    .reg2          (reg2),
    .reg3          (reg3),
    .reg4          (reg4),
    .reg5          (reg5),
    .reg6          (reg6),
    .reg7          (reg7),
    .dataMemValue0 (dm0),
    .dataMemValue1 (dm1),
    .dataMemValue2 (dm2),
    .dataMemValue3 (dm3),
    .dataMemValue4 (dm4),
    .dataMemValue5 (dm5),
    .dataMemValue6 (dm6),
    .dataMemValue7 (dm7),
    .ALUin1        (alu_in1),
    .ALUin2        (alu_in2),
    .ALUout        (alu_out),
    .regDataIn     (reg_data_in)
  );

  logic [7:0][15:0] obs_r;
  logic [7:0][15:0] obs_m;
  assign obs_r = {reg7, reg6, reg5, reg4, reg3, reg2, reg1, reg0};
  assign obs_m = {dm7, dm6, dm5, dm4, dm3, dm2, dm1, dm0};

  typedef struct packed {
    logic [15:0]       a1;
    logic [15:0]       a2;
    logic [15:0]       ao;
    logic [15:0]       rdi;
    logic [7:0]        pc;
    logic [7:0][15:0]  r;
    logic [7:0][15:0]  m;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Architectural model state.
  logic [15:0] mr[8];
  logic [15:0] mm[8];
  logic [7:0]  mpc;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %04h, want %04h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mr[i] = 16'd0;
      mm[i] = 16'd0;
    end
    mpc = 8'd0;
  endtask

  // Executes one instruction on the model and returns the expected observation.
  task automatic model_step(input logic [15:0] ins, output exp_t e);
    int op, d, s1, s2, sh;
    logic [15:0] a, b, y, wd, ic;
    logic [2:0]  ad;
    op = int'(ins[3:0]);
    d  = int'(ins[6:4]);
    s1 = int'(ins[9:7]);
    s2 = int'(ins[12:10]);
    sh = int'(ins[15:13]);
    ic = {10'd0, ins[15:10]};
    a  = mr[s1];
    case (op)
      0:       begin b = mr[s2];   y = a + b; end
      1:       begin b = 16'(sh);  y = a << sh; end
      2:       begin b = 16'(sh);  y = a >> sh; end
      3:       begin b = mr[s2];   y = a & b; end
      4:       begin b = mr[s2];   y = a | b; end
      5:       begin b = ic;       y = a - ic; end
      6, 7, 9: begin b = ic;       y = a + ic; end
      default: begin b = mr[s2];   y = a + b; end
    endcase
    ad = y[2:0];
    wd = (op == 7) ? mm[ad] : y;
    e.a1 = a;
    e.a2 = b;
    e.ao = y;
    e.rdi = wd;
    if (op <= 7) mr[d] = wd;
    if (op == 9) mm[ad] = mr[d];
    if (op == 8) mpc = ins[11:4];
    else         mpc = mpc + 8'd1;
    e.pc = mpc;
    for (int i = 0; i < 8; i++) begin
      e.r[i] = mr[i];
      e.m[i] = mm[i];
    end
  endtask

  function automatic logic [15:0] enc_r(input int op, input int d, input int s1, input int s2);
    return {3'd0, 3'(s2), 3'(s1), 3'(d), 4'(op)};
  endfunction
  function automatic logic [15:0] enc_i(input int op, input int d, input int s1, input int imm);
    return {6'(imm), 3'(s1), 3'(d), 4'(op)};
  endfunction
  function automatic logic [15:0] enc_s(input int op, input int d, input int s1, input int sh);
    return {3'(sh), 3'd0, 3'(s1), 3'(d), 4'(op)};
  endfunction
  function automatic logic [15:0] enc_j(input int j);
    return {3'd0, 9'(j), 4'd8};
  endfunction

  // Drive an instruction now and push its expected outcome.
  task automatic drive(input logic [15:0] ins);
    exp_t e;
    imem.instr = ins;
    model_step(ins, e);
    q.push_back(e);
  endtask

  task automatic exec(input logic [15:0] ins);
    @(negedge clk);
    drive(ins);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"}, {8'd0, imem.pc}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_reg%0d", tag, i), obs_r[i], 16'd0);
      chk($sformatf("%s_mem%0d", tag, i), obs_m[i], 16'd0);
    end
  endtask

  // Monitor: combinational nets mid-cycle, committed state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q[0];
        chk("ALUin1", alu_in1, e.a1);
        chk("ALUin2", alu_in2, e.a2);
        chk("ALUout", alu_out, e.ao);
        chk("regDataIn", reg_data_in, e.rdi);
        @(posedge clk);
        #1;
        chk("pc", {8'd0, imem.pc}, {8'd0, e.pc});
        for (int i = 0; i < 8; i++) begin
          chk($sformatf("reg%0d", i), obs_r[i], e.r[i]);
          chk($sformatf("mem%0d", i), obs_m[i], e.m[i]);
        end
        void'(q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    imem.instr = enc_i(6, 1, 0, 10);
    model_reset();
    #2;
    chk_all_zero("rst_init");
    chk("rst_ALUin1", alu_in1, 16'd0);
    chk("rst_ALUin2", alu_in2, 16'd10);
    chk("rst_ALUout", alu_out, 16'd10);
    chk("rst_regDataIn", reg_data_in, 16'd10);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");

    // ADDI / ADD
    @(negedge clk);
    reset = 1'b0;
    drive(enc_i(6, 1, 0, 10));
    exec(enc_i(6, 2, 0, 9));
    exec(enc_r(0, 3, 1, 2));
    settle();
    chk("add_r3", reg3, 16'd19);
    chk("add_pc", {8'd0, imem.pc}, 16'd3);

    // Shifts and logic
    exec(enc_s(1, 1, 2, 1));
    settle();
    chk("sll_r1", reg1, 16'd18);
    exec(enc_s(2, 1, 2, 1));
    settle();
    chk("srl_r1", reg1, 16'd4);
    exec(enc_i(6, 1, 0, 19));
    exec(enc_r(3, 4, 2, 1));
    exec(enc_r(4, 2, 2, 1));
    settle();
    chk("and_r4", reg4, 16'd1);
    chk("or_r2", reg2, 16'd27);
    exec(enc_i(6, 1, 0, 1));
    exec(enc_i(5, 1, 1, 4));
    settle();
    chk("subi_r1", reg1, 16'hFFFD);

    // Memory, including address wrap
    exec(enc_i(6, 1, 0, 1));
    exec(enc_i(9, 3, 1, 0));
    settle();
    chk("sw_mem1", dm1, 16'd19);
    exec(enc_i(7, 5, 0, 1));
    settle();
    chk("lw_r5", reg5, 16'd19);
    exec(enc_i(6, 6, 0, 9));
    exec(enc_i(9, 2, 6, 0));
    settle();
    chk("sw_wrap_mem1", dm1, 16'd27);

    // Jump, PC wrap, NOP opcodes
    exec(enc_j(9'h105));
    settle();
    chk("jmp_pc", {8'd0, imem.pc}, 16'd5);
    exec(enc_j(9'h0FF));
    exec(enc_r(10, 7, 3, 2));
    settle();
    chk("wrap_pc", {8'd0, imem.pc}, 16'd0);
    for (int op = 10; op < 16; op++) begin
      exec({12'($urandom()), 4'(op)});
    end

    // Random instruction stream
    for (int n = 0; n < 400; n++) begin
      exec(16'($urandom()));
    end
    settle();
    chk("queue_drained", 16'(q.size()), 16'd0);

    // Asynchronous reset between edges discards the in-flight instruction
    @(negedge clk);
    imem.instr = enc_i(6, 1, 0, 5);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("rst_edge");
    model_reset();

    // Restart after reset: first instruction runs from pc 0
    @(negedge clk);
    reset = 1'b0;
    drive(enc_i(6, 7, 0, 33));
    settle();
    chk("restart_r7", reg7, 16'd33);
    chk("restart_pc", {8'd0, imem.pc}, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
